ex_pipe_ctrl: RTL
=================

// Module: ex_pipe_ctrl
// PURPOSE
//  Pipeline controller for the 16-bit execute stage. Keeps a destination-tag scoreboard for EX/MEM/WB.
//  Drives the ALU operand forwarding selects and the load-use stall. Squashes IF/ID on a taken branch (PcSrc).
//  Sequences HALT drain. Sits beside the ID/EX register; its outputs gate the IF/ID and ID/EX registers.
// PARAMETERS
//  REG_W  3   register-specifier width (8 GPRs, all forwardable, no hardwired zero)
//  CNT_W  16  width of the saturating stall/flush performance counters
// PORTS
//  Clk        in   1      clock; all state updates on rising edge
//  Rst        in   1      synchronous reset, active high
//  IdValid    in   1      ID holds a real instruction
//  IdRs,IdRt  in   REG_W  source specifiers of the ID instruction
//  IdUsesRs   in   1      ID instruction reads Rs
//  IdUsesRt   in   1      ID instruction reads Rt
//  IdRd       in   REG_W  destination of the ID instruction
//  IdWrites   in   1      ID instruction writes Rd
//  IdLoad     in   1      ID instruction is a load
//  IdHalt     in   1      ID instruction is HALT
//  PcSrc      in   1      taken branch/jump resolving in EX this cycle
//  MemBusy    in   1      data memory not ready; whole pipe freezes
//  FwdASel    out  2      EX operand A (Reg1) source: 00 regfile, 01 MEM result, 10 WB result
//  FwdBSel    out  2      EX operand B (Reg2) source: same encoding
//  StallIf    out  1      hold PC and IF/ID
//  StallId    out  1      hold the ID instruction (do not issue)
//  BubbleEx   out  1      load NOP (valid=0) into ID/EX
//  FlushIfId  out  1      load NOP into IF/ID
//  Halted     out  1      HALT has retired; pipeline stopped
//  StallCnt   out  CNT_W  load-use stall cycles, saturating
//  FlushCnt   out  CNT_W  branch flush events, saturating
// BEHAVIOUR
//  Reset: all tag valids 0; state RUN; Halted 0; counters 0.
//  Reset outputs: Fwd*Sel 00; StallIf/StallId/BubbleEx/FlushIfId 0.
//  Tag slots EX, MEM, WB hold {valid, rd, writes, load, halt, rs, rt, usesRs, usesRt}; rs/rt/uses fields are EX only.
//  Advance each non-frozen cycle: WB<=MEM, MEM<=EX, EX<=ID (EX gets valid=0 when BubbleEx is set).
//  Fwd selects are combinational from registers only:
//   EX.rs==MEM.rd && MEM.valid && MEM.writes -> 01.
//   Otherwise, same match on WB -> 10.
//   Otherwise -> 00.
//   Same rules apply to rt. MEM beats WB. Gated by EX.valid and EX.usesRx.
//  Priority, evaluated each cycle (highest first):
//   1 Rst.
//   2 MemBusy: StallIf=StallId=1, BubbleEx=0, no tag advance, counters hold.
//   3 PcSrc: FlushIfId=1, BubbleEx=1, StallIf=0; FlushCnt++. A HALT or load-use hazard in ID is discarded.
//   4 Load-use: EX.valid && EX.load && EX.writes && IdValid && (IdUsesRs&&IdRs==EX.rd || IdUsesRt&&IdRt==EX.rd).
//     Response: StallIf=StallId=1, BubbleEx=1; StallCnt++. Exactly one bubble; the load's value then forwards from WB (10).
//   5 Otherwise normal advance.
//  FSM:
//   RUN -> DRAIN when an IdHalt instruction issues to EX (IdValid, not stalled, not flushed).
//   DRAIN: StallIf=StallId=1, BubbleEx=1 every cycle. -> HALTED when the halt tag reaches WB.
//   HALTED: Halted=1, StallIf=StallId=BubbleEx=1. Only Rst leaves this state.
//  MemBusy freezes DRAIN progress. PcSrc in DRAIN is impossible: older branches have already resolved.
//  Counters saturate at all-ones; no wrap.
// STRUCTURE
//  Shared include ex_ctrl_defs.vh holds:
//   FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
//   State codes RUN=2'b00, DRAIN=2'b01, HALTED=2'b10.
//  One sub-module, hazard_tag_reg: one scoreboard slot with enable (freeze) and clear (bubble); instantiated x3.
//  Hazard/forward compare logic and the FSM stay in the top module.
// TESTING
//  1 EX ADD r3 then ID ADD r4,r3,r1 -> next cycle FwdASel=01; after one bubble, FwdASel=10.
//  2 LD r2 in EX, ID uses Rt=r2 -> StallIf=StallId=BubbleEx=1 for exactly 1 cycle.
//    Next cycle FwdBSel=10; StallCnt=1.
//  3 PcSrc=1 with HALT in ID -> FlushIfId=BubbleEx=1, FlushCnt=1; FSM stays RUN, Halted stays 0.
//  4 MemBusy=1 for 3 cycles during a load-use hazard -> tags frozen, StallCnt unchanged.
//    On release -> the single bubble still occurs.
//  5 HALT issues -> DRAIN; Halted=1 three advancing cycles later. Rst=1 mid-DRAIN -> RUN, all outputs at reset values.
//  6 Force StallCnt to 16'hFFFE and repeat load-use stalls -> counter holds at 16'hFFFF.

Source files
------------

// File: rtl/ex_pipe_ctrl_pkg.sv
// Shared types and encodings for the execute-stage pipeline controller.
// Scoreboard tag layouts, forwarding select codes and controller states live here.
package ex_pipe_ctrl_pkg;

  localparam int REG_W = 3;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } ctrl_state_e;

  // EX keeps the source specifiers so forwarding can be resolved from registers only.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             writes;
    logic             load;
    logic             halt;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             usesRs;
    logic             usesRt;
  } exTag_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             writes;
    logic             halt;
  } dstTag_t;

  // The younger producer in MEM wins over the older one in WB.
  function automatic logic [1:0] fwdSel(input logic needed, input logic [REG_W-1:0] src,
                                        input dstTag_t mem, input dstTag_t wb);
    logic [1:0] sel;
    sel = FWD_REG;
    if (needed) begin
      if (mem.valid && mem.writes && (mem.rd == src)) begin
        sel = FWD_MEM;
      end else if (wb.valid && wb.writes && (wb.rd == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_pipe_ctrl_hazard_tag_reg.sv
// One scoreboard slot: holds its tag while frozen, loads an empty tag on a bubble.
module ex_pipe_ctrl_hazard_tag_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] tag_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q <= '0;
    end else if (en_i) begin
      tag_q <= clr_i ? '0 : d_i;
    end
  end

  assign q_o = tag_q;

endmodule

// File: rtl/ex_pipe_ctrl.sv
// Execute-stage pipeline controller: forwarding selects, load-use stall,
// branch squash, HALT drain sequencing and saturating stall/flush counters.
module ex_pipe_ctrl
  import ex_pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idValid_i,
  input  logic [REG_W-1:0] idRs_i,
  input  logic [REG_W-1:0] idRt_i,
  input  logic             idUsesRs_i,
  input  logic             idUsesRt_i,
  input  logic [REG_W-1:0] idRd_i,
  input  logic             idWrites_i,
  input  logic             idLoad_i,
  input  logic             idHalt_i,
  input  logic             pcSrc_i,
  input  logic             memBusy_i,
  output logic [1:0]       fwdASel_o,
  output logic [1:0]       fwdBSel_o,
  output logic             stallIf_o,
  output logic             stallId_o,
  output logic             bubbleEx_o,
  output logic             flushIfId_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stallCnt_o,
  output logic [CNT_W-1:0] flushCnt_o
);

  exTag_t      exTag_d, exTag_q;
  dstTag_t     memTag_d, memTag_q, wbTag_q;
  ctrl_state_e state_q;
  logic        halted_q;
  logic [CNT_W-1:0] stallCnt_q, flushCnt_q;

  logic advance, running, loadUse, flushEvent, stallEvent, haltIssue;

  always_comb begin
    exTag_d        = '0;
    exTag_d.valid  = idValid_i;
    exTag_d.rd     = idRd_i;
    exTag_d.writes = idWrites_i;
    exTag_d.load   = idLoad_i;
    exTag_d.halt   = idHalt_i;
    exTag_d.rs     = idRs_i;
    exTag_d.rt     = idRt_i;
    exTag_d.usesRs = idUsesRs_i;
    exTag_d.usesRt = idUsesRt_i;
  end

  always_comb begin
    memTag_d        = '0;
    memTag_d.valid  = exTag_q.valid;
    memTag_d.rd     = exTag_q.rd;
    memTag_d.writes = exTag_q.writes;
    memTag_d.halt   = exTag_q.halt;
  end

  assign advance = !memBusy_i;
  assign running = (state_q == ST_RUN);
  assign loadUse = exTag_q.valid && exTag_q.load && exTag_q.writes && idValid_i &&
                   ((idUsesRs_i && (idRs_i == exTag_q.rd)) ||
                    (idUsesRt_i && (idRt_i == exTag_q.rd)));

  assign flushEvent = advance && running && pcSrc_i;
  assign stallEvent = advance && running && !pcSrc_i && loadUse;
  assign haltIssue  = advance && running && !pcSrc_i && !loadUse && idValid_i && idHalt_i;

  // A frozen memory outranks everything; draining/halted keeps the front end shut.
  always_comb begin
    stallIf_o   = 1'b0;
    stallId_o   = 1'b0;
    bubbleEx_o  = 1'b0;
    flushIfId_o = 1'b0;
    if (rst_i) begin
      stallIf_o = 1'b0;
    end else if (memBusy_i) begin
      stallIf_o = 1'b1;
      stallId_o = 1'b1;
    end else if (!running) begin
      stallIf_o  = 1'b1;
      stallId_o  = 1'b1;
      bubbleEx_o = 1'b1;
    end else if (pcSrc_i) begin
      flushIfId_o = 1'b1;
      bubbleEx_o  = 1'b1;
    end else if (loadUse) begin
      stallIf_o  = 1'b1;
      stallId_o  = 1'b1;
      bubbleEx_o = 1'b1;
    end
  end

  ex_pipe_ctrl_hazard_tag_reg #(.W($bits(exTag_t))) u_exTag (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(advance), .clr_i(bubbleEx_o),
    .d_i(exTag_d), .q_o(exTag_q)
  );

  ex_pipe_ctrl_hazard_tag_reg #(.W($bits(dstTag_t))) u_memTag (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(advance), .clr_i(1'b0),
    .d_i(memTag_d), .q_o(memTag_q)
  );

  ex_pipe_ctrl_hazard_tag_reg #(.W($bits(dstTag_t))) u_wbTag (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(advance), .clr_i(1'b0),
    .d_i(memTag_q), .q_o(wbTag_q)
  );

  assign fwdASel_o = fwdSel(exTag_q.valid && exTag_q.usesRs, exTag_q.rs, memTag_q, wbTag_q);
  assign fwdBSel_o = fwdSel(exTag_q.valid && exTag_q.usesRt, exTag_q.rt, memTag_q, wbTag_q);

  // HALT retires when its tag leaves WB on an advancing edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
    end else if (advance) begin
      case (state_q)
        ST_RUN: begin
          if (haltIssue) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (wbTag_q.valid && wbTag_q.halt) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end
        end
        ST_HALTED: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (stallEvent && (stallCnt_q != '1)) stallCnt_q <= stallCnt_q + CNT_W'(1);
      if (flushEvent && (flushCnt_q != '1)) flushCnt_q <= flushCnt_q + CNT_W'(1);
    end
  end

  assign halted_o   = halted_q;
  assign stallCnt_o = stallCnt_q;
  assign flushCnt_o = flushCnt_q;

endmodule
